measure_position_multi: RTL

Multi-channel successor to the single-object centroid block: it accumulates pixel count and x/y coordinate sums for NUM_CH independent object masks over one video frame, then computes each centroid with a shared-latency sequential divider. It sits after the per-channel colour/delta classifiers and before the tracking/overlay logic, replacing the single-cycle combinational divide with a fixed-latency iterative one. It adds a pixel-valid qualifier, a per-channel object-found flag and an overrun indication.

---
 rtl/measure_position_multi_pkg.sv | 26 ++
 rtl/measure_position_multi_seq_divider.sv | 76 +++++++
 rtl/measure_position_multi.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/measure_position_multi_pkg.sv
// Shared types and helpers for the multi-channel centroid block.
// Holds the state encoding, width helper and default geometry.
package measure_position_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DEF_INPUT_WIDTH  = 11;
  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_FRAME_X_MAX  = 640;
  localparam int DEF_FRAME_Y_MAX  = 480;
  localparam int DEF_COUNT_THRESH = 40;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int t = v - 1; t > 0; t = t >> 1)
      r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/measure_position_multi_seq_divider.sv
// Restoring divider: one quotient bit per cycle, SUM_W cycles.
// quotient_o/done_o reflect the step completing on the current edge.
module measure_position_multi_seq_divider
  import measure_position_multi_pkg::*;
#(
  parameter int SUM_W   = 30,
  parameter int COUNT_W = 19,
  parameter int Q_W     = 11
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic               clr_i,
  input  logic               start_i,
  input  logic [SUM_W-1:0]   dividend_i,
  input  logic [COUNT_W-1:0] divisor_i,
  output logic [Q_W-1:0]     quotient_o,
  output logic               done_o
);

  localparam int CNT_W = clog2(SUM_W + 1);

  logic               act_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [COUNT_W-1:0] rem_q;
  logic [COUNT_W-1:0] dvs_q;
  logic [SUM_W-1:0]   quo_q;

  logic [COUNT_W:0]   shf;
  logic               ge;
  logic [COUNT_W-1:0] rem_d;
  logic [SUM_W-1:0]   quo_d;

  always_comb begin
    shf = {rem_q, quo_q[SUM_W-1]};
    ge  = shf >= {1'b0, dvs_q};
    if (ge) begin
      rem_d = COUNT_W'(shf - {1'b0, dvs_q});
      quo_d = {quo_q[SUM_W-2:0], 1'b1};
    end else begin
      rem_d = shf[COUNT_W-1:0];
      quo_d = {quo_q[SUM_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      act_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
    end else if (clr_i) begin
      act_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
    end else if (start_i) begin
      act_q <= 1'b1;
      cnt_q <= CNT_W'(SUM_W);
      rem_q <= '0;
      dvs_q <= divisor_i;
      quo_q <= dividend_i;
    end else if (act_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1))
        act_q <= 1'b0;
    end
  end

  assign done_o     = act_q && (cnt_q == CNT_W'(1));
  assign quotient_o = quo_d[Q_W-1:0];

endmodule

// File: rtl/measure_position_multi.sv
// Per-channel pixel count / coordinate sums over a frame, then
// centroids through a pair of shared sequential dividers.
module measure_position_multi
  import measure_position_multi_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int FRAME_X_MAX  = DEF_FRAME_X_MAX,
  parameter int FRAME_Y_MAX  = DEF_FRAME_Y_MAX,
  parameter int COUNT_THRESH = DEF_COUNT_THRESH
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic                          enable,
  input  logic                          pix_valid,
  input  logic [INPUT_WIDTH-1:0]        vga_x,
  input  logic [INPUT_WIDTH-1:0]        vga_y,
  input  logic [NUM_CH-1:0]             mask,
  output logic [NUM_CH*INPUT_WIDTH-1:0] x_position,
  output logic [NUM_CH*INPUT_WIDTH-1:0] y_position,
  output logic [NUM_CH-1:0]             obj_found,
  output logic                          xy_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int COUNT_W =
    clog2((FRAME_X_MAX + 1) * (FRAME_Y_MAX + 1) + 1);
  localparam int SUM_W = INPUT_WIDTH + COUNT_W;
  localparam int CH_W  = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int PAD_W = SUM_W - INPUT_WIDTH;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic [COUNT_W-1:0] cnt_q    [NUM_CH];
  logic [SUM_W-1:0]   xs_q     [NUM_CH];
  logic [SUM_W-1:0]   ys_q     [NUM_CH];
  logic [COUNT_W-1:0] sn_cnt_q [NUM_CH];
  logic [SUM_W-1:0]   sn_xs_q  [NUM_CH];
  logic [SUM_W-1:0]   sn_ys_q  [NUM_CH];

  logic [INPUT_WIDTH-1:0] rx_q [NUM_CH];
  logic [INPUT_WIDTH-1:0] ry_q [NUM_CH];
  logic [NUM_CH-1:0]      rf_q;

  logic [NUM_CH*INPUT_WIDTH-1:0] xpos_q;
  logic [NUM_CH*INPUT_WIDTH-1:0] ypos_q;
  logic [NUM_CH-1:0]             found_q;
  logic                          ovr_q;

  state_e          st_q, st_d;
  logic [CH_W-1:0] ch_q, ch_d;

  logic fe, busy_w, take;
  logic start, stage, commit;
  logic xdone, ydone, div_done;
  logic [INPUT_WIDTH-1:0] qx, qy;
  logic cur_f;
  logic [INPUT_WIDTH-1:0] cur_x, cur_y;

  assign fe = pix_valid
           && (vga_x == INPUT_WIDTH'(FRAME_X_MAX))
           && (vga_y == INPUT_WIDTH'(FRAME_Y_MAX));
  assign busy_w = (st_q == ST_LOAD) || (st_q == ST_DIV);
  assign take   = enable && fe && !busy_w;

  // Live accumulators restart on every frame end, busy or not.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= '0;
        xs_q[c]  <= '0;
        ys_q[c]  <= '0;
      end
    end else if (!enable || fe) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= '0;
        xs_q[c]  <= '0;
        ys_q[c]  <= '0;
      end
    end else if (pix_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (mask[c]) begin
          cnt_q[c] <= cnt_q[c] + COUNT_W'(1);
          xs_q[c]  <= xs_q[c] + {{PAD_W{1'b0}}, vga_x};
          ys_q[c]  <= ys_q[c] + {{PAD_W{1'b0}}, vga_y};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sn_cnt_q[c] <= '0;
        sn_xs_q[c]  <= '0;
        sn_ys_q[c]  <= '0;
      end
    end else if (!enable) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sn_cnt_q[c] <= '0;
        sn_xs_q[c]  <= '0;
        sn_ys_q[c]  <= '0;
      end
    end else if (take) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sn_cnt_q[c] <= cnt_q[c];
        sn_xs_q[c]  <= xs_q[c];
        sn_ys_q[c]  <= ys_q[c];
      end
    end
  end

  always_comb begin
    st_d   = st_q;
    ch_d   = ch_q;
    start  = 1'b0;
    stage  = 1'b0;
    commit = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (take) begin
          st_d = ST_LOAD;
          ch_d = '0;
        end
      end
      ST_LOAD: begin
        start = 1'b1;
        st_d  = ST_DIV;
      end
      ST_DIV: begin
        if (div_done) begin
          stage = 1'b1;
          if (ch_q == LAST_CH) begin
            commit = 1'b1;
            st_d   = ST_DONE;
          end else begin
            ch_d = ch_q + CH_W'(1);
            st_d = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        st_d = take ? ST_LOAD : ST_IDLE;
        ch_d = '0;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      st_q <= ST_IDLE;
      ch_q <= '0;
    end else if (!enable) begin
      st_q <= ST_IDLE;
      ch_q <= '0;
    end else begin
      st_q <= st_d;
      ch_q <= ch_d;
    end
  end

  measure_position_multi_seq_divider #(
    .SUM_W(SUM_W), .COUNT_W(COUNT_W), .Q_W(INPUT_WIDTH)
  ) u_div_x (
    .clk(clk), .aresetn(aresetn), .clr_i(!enable),
    .start_i(start),
    .dividend_i(sn_xs_q[ch_q]),
    .divisor_i(sn_cnt_q[ch_q]),
    .quotient_o(qx), .done_o(xdone)
  );

  measure_position_multi_seq_divider #(
    .SUM_W(SUM_W), .COUNT_W(COUNT_W), .Q_W(INPUT_WIDTH)
  ) u_div_y (
    .clk(clk), .aresetn(aresetn), .clr_i(!enable),
    .start_i(start),
    .dividend_i(sn_ys_q[ch_q]),
    .divisor_i(sn_cnt_q[ch_q]),
    .quotient_o(qy), .done_o(ydone)
  );

  assign div_done = xdone && ydone;

  // Below-threshold channels report the all-ones "no object" code.
  assign cur_f = sn_cnt_q[ch_q] >= COUNT_W'(COUNT_THRESH);
  assign cur_x = cur_f ? qx : '1;
  assign cur_y = cur_f ? qy : '1;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rx_q[c] <= '0;
        ry_q[c] <= '0;
      end
      rf_q <= '0;
    end else if (!enable) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rx_q[c] <= '0;
        ry_q[c] <= '0;
      end
      rf_q <= '0;
    end else if (stage) begin
      rx_q[ch_q] <= cur_x;
      ry_q[ch_q] <= cur_y;
      rf_q[ch_q] <= cur_f;
    end
  end

  // Last channel bypasses staging so all channels land together.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      xpos_q  <= '0;
      ypos_q  <= '0;
      found_q <= '0;
    end else if (!enable) begin
      xpos_q  <= '0;
      ypos_q  <= '0;
      found_q <= '0;
    end else if (commit) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (CH_W'(c) == ch_q) begin
          xpos_q[c*INPUT_WIDTH +: INPUT_WIDTH] <= cur_x;
          ypos_q[c*INPUT_WIDTH +: INPUT_WIDTH] <= cur_y;
          found_q[c] <= cur_f;
        end else begin
          xpos_q[c*INPUT_WIDTH +: INPUT_WIDTH] <= rx_q[c];
          ypos_q[c*INPUT_WIDTH +: INPUT_WIDTH] <= ry_q[c];
          found_q[c] <= rf_q[c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)
      ovr_q <= 1'b0;
    else
      ovr_q <= enable && fe && busy_w;
  end

  assign x_position = xpos_q;
  assign y_position = ypos_q;
  assign obj_found  = found_q;
  assign xy_valid   = (st_q == ST_DONE);
  assign busy       = busy_w;
  assign overrun    = ovr_q;

endmodule
